// File: rtl/dwt_downsample.sv
// Forward-DWT decimator: keeps one of every two low/high analysis-filter pairs
// and buffers the kept coefficients in a 2-entry FIFO with a frame-end marker.
module dwt_downsample #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 256,
    parameter int KEEP_ODD  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [DW-1:0] lo_in,
    input  logic [DW-1:0] hi_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] ca_out,
    output logic [DW-1:0] cd_out,
    output logic          out_last,
    output logic          frame_err
);

    localparam int            PW       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] END_POS  = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 2 + KEEP_ODD);
    localparam logic          KEEP_BIT = (KEEP_ODD != 0);

    // Handshake: a transfer happens on a rising edge where clk_enable, valid
    // and ready are all high; valid/data never depend on ready on either side.
    logic [PW-1:0] pos;
    logic [PW-1:0] eff_pos;
    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [DW-1:0] lo_mem   [2];
    logic [DW-1:0] hi_mem   [2];
    logic          last_mem [2];
    logic          accept;
    logic          pop;
    logic          push;
    logic          keep;
    logic          is_last;

    assign in_ready  = !reset && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = clk_enable & in_valid & in_ready;
    assign pop       = clk_enable & out_valid & out_ready;

    // in_first overrides the running position so a resync sample is position 0
    assign eff_pos = in_first ? '0 : pos;
    assign keep    = (eff_pos[0] == KEEP_BIT);
    assign is_last = (eff_pos == LAST_POS);
    assign push    = accept & keep;

    assign ca_out   = lo_mem[rd_ptr];
    assign cd_out   = hi_mem[rd_ptr];
    assign out_last = last_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos       <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            pos <= (eff_pos == END_POS) ? '0 : eff_pos + 1'b1;
            if (in_first && (pos != '0)) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                lo_mem[i]   <= '0;
                hi_mem[i]   <= '0;
                last_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                lo_mem[wr_ptr]   <= lo_in;
                hi_mem[wr_ptr]   <= hi_in;
                last_mem[wr_ptr] <= is_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dwt_downsample.sv
// Bench for dwt_downsample: even- and odd-phase instances share one stimulus
// stream; a per-instance reference model predicts every coefficient pair.
module tb_dwt_downsample;

    localparam int DW        = 16;
    localparam int FRAME_LEN = 8;
    localparam int EW        = 2 * DW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          in_valid;
    logic          in_first;
    logic [DW-1:0] lo_in;
    logic [DW-1:0] hi_in;
    logic          out_ready;

    logic          in_ready_w  [2];
    logic          out_valid_w [2];
    logic          out_last_w  [2];
    logic          frame_err_w [2];
    logic [DW-1:0] ca_w        [2];
    logic [DW-1:0] cd_w        [2];

    int checks = 0;
    int errors = 0;

    // reference model state, one slot per instance (index = KEEP_ODD)
    logic [EW-1:0] exp_q [2][$];
    int            mpos  [2];
    bit            merr  [2];

    always #5 clk = ~clk;

    dwt_downsample #(.DW(DW), .FRAME_LEN(FRAME_LEN), .KEEP_ODD(0)) u_even (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_first(in_first),
        .lo_in(lo_in), .hi_in(hi_in),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .ca_out(ca_w[0]), .cd_out(cd_w[0]), .out_last(out_last_w[0]),
        .frame_err(frame_err_w[0])
    );

    dwt_downsample #(.DW(DW), .FRAME_LEN(FRAME_LEN), .KEEP_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_first(in_first),
        .lo_in(lo_in), .hi_in(hi_in),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .ca_out(ca_w[1]), .cd_out(cd_w[1]), .out_last(out_last_w[1]),
        .frame_err(frame_err_w[1])
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Monitor + scoreboard: samples on the falling edge, where inputs and
    // outputs are stable, and predicts the transfers of the next rising edge.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        int            p;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                chk("rst_out_valid", d, 64'(out_valid_w[d]), 64'd0);
                chk("rst_in_ready", d, 64'(in_ready_w[d]), 64'd0);
                chk("rst_frame_err", d, 64'(frame_err_w[d]), 64'd0);
                chk("rst_data", d, {31'd0, out_last_w[d], ca_w[d], cd_w[d]}, 64'd0);
                exp_q[d].delete();
                mpos[d] = 0;
                merr[d] = 1'b0;
            end else begin
                chk("frame_err", d, 64'(frame_err_w[d]), 64'(merr[d]));
                chk("out_valid", d, 64'(out_valid_w[d]), 64'(exp_q[d].size() != 0));
                chk("in_ready", d, 64'(in_ready_w[d]), 64'(exp_q[d].size() < 2));
                if (out_valid_w[d] && exp_q[d].size() != 0) begin
                    e = exp_q[d][0];
                    chk("ca_out", d, 64'(ca_w[d]), 64'(e[2*DW-1:DW]));
                    chk("cd_out", d, 64'(cd_w[d]), 64'(e[DW-1:0]));
                    chk("out_last", d, 64'(out_last_w[d]), 64'(e[2*DW]));
                    if (clk_enable && out_ready) begin
                        void'(exp_q[d].pop_front());
                    end
                end
                if (clk_enable && in_valid && in_ready_w[d]) begin
                    p = in_first ? 0 : mpos[d];
                    if (in_first && mpos[d] != 0) merr[d] = 1'b1;
                    if ((p % 2) == d) begin
                        exp_q[d].push_back({(p == FRAME_LEN - 2 + d), lo_in, hi_in});
                    end
                    mpos[d] = (p + 1) % FRAME_LEN;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input int k);
        in_valid = v;
        in_first = f;
        lo_in    = DW'(k);
        hi_in    = DW'(-k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        int k;
        bit acc;
        reset      = 1'b1;
        clk_enable = 1'b1;
        out_ready  = 1'b1;
        drive(1'b0, 1'b0, 0);
        tick();
        do_reset();

        // two back-to-back frames, lo=1..8 / hi=-1..-8, no in_first
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            drive(1'b1, 1'b0, (i % FRAME_LEN) + 1);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        tick();
        tick();

        // backpressure: out_ready low, then drain; value advances on even-instance accept
        do_reset();
        out_ready = 1'b0;
        k = 1;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 6);
            drive(1'b1, 1'b0, k);
            acc = in_ready_w[0] && clk_enable;
            tick();
            if (acc) k++;
        end
        drive(1'b0, 1'b0, 0);
        out_ready = 1'b1;
        tick();
        tick();

        // in_first at position 3
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, (i == 3), 20 + i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        tick();
        tick();

        // clk_enable low for 5 cycles mid-stream
        do_reset();
        for (int i = 0; i < 15; i++) begin
            clk_enable = !(i >= 5 && i < 10);
            drive(1'b1, 1'b0, 40 + i);
            tick();
        end
        clk_enable = 1'b1;
        drive(1'b0, 1'b0, 0);
        tick();
        tick();

        // reset with two entries buffered and pos=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            out_ready = (i < 2);
            drive(1'b1, 1'b0, 60 + i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 70 + i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        tick();
        tick();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clk_enable = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 65535)) - 32768);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            reset = 1'b0;
        end
        drive(1'b0, 1'b0, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dwt_downsample.md
# dwt_downsample

Forward-DWT decimator for the ECG feature front end; the analysis-side counterpart of the inverse-wavelet upsampler. It takes paired low-pass/high-pass analysis-filter outputs as a valid/ready stream and keeps one sample of every two (selectable phase). It emits approximation/detail coefficient pairs through a 2-entry output buffer and marks the last coefficient of each fixed-length ECG frame. It sits between the analysis filter bank and the LSTM feature buffer.

## Interface
- DW, 16, sample/coefficient width (signed two's complement)
- FRAME_LEN, 256, input samples per frame; even, ≥ 2
- KEEP_ODD, 0, 0 = keep input positions 0,2,4…; 1 = keep 1,3,5…

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_enable  in  1  global enable; all state frozen and no transfers while low
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept input pair
- in_first  in  1  qualifies the current input as frame position 0
- lo_in  in  DW  low-pass filter output (signed)
- hi_in  in  DW  high-pass filter output (signed)
- out_valid  out  1  coefficient pair available
- out_ready  in  1  downstream accepts pair
- ca_out  out  DW  approximation coefficient (kept lo_in, unmodified)
- cd_out  out  DW  detail coefficient (kept hi_in, unmodified)
- out_last  out  1  pair is the last kept coefficient of its frame
- frame_err  out  1  sticky: in_first seen mid-frame

## Operation
- Input transfer (accept): clk_enable & in_valid & in_ready at a rising edge.
- Output transfer (pop): clk_enable & out_valid & out_ready at a rising edge.
- Position counter pos, 0..FRAME_LEN-1, advances by 1 per accept and wraps FRAME_LEN-1 → 0.
- An accept with in_first=1 treats the sample as position 0, then sets pos=1.
  - If pos≠0 at that accept, set frame_err; it stays set until reset.
- Keep rule: the sample at effective position p is kept iff p[0]==KEEP_ODD. Discarded samples still advance pos.
- Kept samples push {lo_in, hi_in, last} into a 2-entry FIFO.
  - last = (p == FRAME_LEN-2+KEEP_ODD).
- No arithmetic is performed; values pass bit-exact, with no rounding or saturation.
- in_ready = !reset & (count < 2).
  - It gates all accepts, including samples that will be discarded.
- out_valid = (count ≠ 0); ca_out/cd_out/out_last present the FIFO head.
- Push and pop in the same cycle: count unchanged, order preserved.
- Push is impossible at count=2 because in_ready=0.
- Pop at count=0 cannot occur because out_valid=0.
- clk_enable low: pos, FIFO and frame_err hold; out_valid/data hold stable; no accept or pop is counted.

## Timing
- Reset (async assert): count=0, pos=0, frame_err=0, out_valid=0, ca_out=0, cd_out=0, out_last=0, in_ready=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Latency: a kept sample accepted at edge N gives out_valid=1 with its data after edge N (1 cycle), provided the FIFO was empty.
- Throughput: 1 input/cycle sustained when out_ready=1, giving output at 1 pair per 2 cycles.
- out_valid and data stay stable until popped; downstream may hold out_ready low indefinitely.
- Reset mid-frame discards FIFO contents and the partial frame. The next accepted sample is position 0 regardless of in_first.

## Test plan
- FRAME_LEN=8, KEEP_ODD=0, out_ready=1, 8 back-to-back accepts of lo=1..8, hi=-1..-8:
  - Outputs (1,-1),(3,-3),(5,-5),(7,-7), each 1 cycle after its accept.
  - out_last only on (7,-7).
  - Second frame repeats the same pattern with no in_first required.
- Same stimulus with KEEP_ODD=1:
  - Outputs (2,-2),(4,-4),(6,-6),(8,-8).
  - out_last on (8,-8).
- Backpressure, out_ready=0, in_valid=1 continuously, lo=1..:
  - Samples 1,2,3 accepted; in_ready=0 after the 3rd accept; out_valid=1 with (1,-1) held.
  - Raising out_ready drains (1,-1),(3,-3), then input resumes at 4.
  - No loss or duplication.
- in_first at pos=3 (FRAME_LEN=8):
  - frame_err=1 next cycle, staying set.
  - That sample is kept as position 0.
  - out_last moves to the sample 6 accepts later.
- clk_enable=0 for 5 cycles mid-stream with in_valid=1 and out_ready=1:
  - No accepts or pops; outputs frozen.
  - Resumes exactly where stopped.
- reset pulse with 2 entries buffered and pos=5:
  - out_valid=0 and frame_err=0 immediately.
  - Next input produces the position-0 coefficient first.
